// File: rtl/pwm_duty_gen.sv
// ============================================================================
//  Module      : pwm_duty_gen
//  Description : Fixed-frequency PWM generator driven by a 3-bit speed level
//                (0..4). Level changes take effect only at period boundaries.
//                Optional build macro SOFT_START_EN limits level increases to
//                one step per period.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_gen #(
    parameter int PERIOD    = 100,
    parameter int CNT_WIDTH = 7
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic [2:0] i_pwm_state,
    output logic       o_pwm,
    output logic       o_period_start,
    output logic [2:0] o_active_level
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]   c_CMP1     = (CNT_WIDTH+1)'(PERIOD / 4);
    localparam logic [CNT_WIDTH:0]   c_CMP2     = (CNT_WIDTH+1)'(PERIOD / 2);
    localparam logic [CNT_WIDTH:0]   c_CMP3     = (CNT_WIDTH+1)'((3 * PERIOD) / 4);
    localparam logic [CNT_WIDTH:0]   c_CMP4     = (CNT_WIDTH+1)'(PERIOD);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2:0]           r_level;
    logic                 r_pwm;
    logic                 r_period_start;

    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [2:0]           w_level_nxt;
    logic                 w_pwm_nxt;
    logic                 w_period_start_nxt;
    logic [2:0]           w_target;
    logic [2:0]           w_wrap_level;

    // Compare value is one bit wider than the counter so level 4 (cmp == PERIOD)
    // stays high for the whole period even when PERIOD == 2**CNT_WIDTH.
    function automatic logic [CNT_WIDTH:0] f_cmp(input logic [2:0] lvl);
        case (lvl)
            3'd1:    f_cmp = c_CMP1;
            3'd2:    f_cmp = c_CMP2;
            3'd3:    f_cmp = c_CMP3;
            3'd4:    f_cmp = c_CMP4;
            default: f_cmp = '0;
        endcase
    endfunction

    assign w_target = (i_pwm_state > 3'd4) ? 3'd0 : i_pwm_state;

`ifdef SOFT_START_EN
    // Increases ramp one step per wrap; decreases apply immediately.
    always_comb begin
        w_wrap_level = r_level;
        if (w_target < r_level) begin
            w_wrap_level = w_target;
        end else if (w_target > r_level) begin
            w_wrap_level = r_level + 3'd1;
        end
    end
`else
    assign w_wrap_level = w_target;
`endif

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_level_nxt        = r_level;
        w_period_start_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    // The enabling edge is itself a wrap event.
                    w_state_nxt        = S_RUN;
                    w_cnt_nxt          = '0;
                    w_level_nxt        = w_wrap_level;
                    w_period_start_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = c_CNT_LAST;
                    w_level_nxt = 3'd0;
                end
            end
            S_RUN: begin
                if (!i_enable) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = c_CNT_LAST;
                    w_level_nxt = 3'd0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_level_nxt        = w_wrap_level;
                    w_period_start_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = c_CNT_LAST;
                w_level_nxt = 3'd0;
            end
        endcase

        // Output is registered, so it is derived from the next-cycle counter.
        w_pwm_nxt = (w_state_nxt == S_RUN) && ({1'b0, w_cnt_nxt} < f_cmp(w_level_nxt));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= c_CNT_LAST;
            r_level        <= 3'd0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_level        <= w_level_nxt;
            r_pwm          <= w_pwm_nxt;
            r_period_start <= w_period_start_nxt;
        end
    end

    assign o_pwm          = r_pwm;
    assign o_period_start = r_period_start;
    assign o_active_level = r_level;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_gen.sv
// ============================================================================
//  Module      : tb_pwm_duty_gen
//  Description : Scoreboard bench for pwm_duty_gen (PERIOD = 8); honours the
//                SOFT_START_EN build macro in its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_gen;

    localparam int PERIOD    = 8;
    localparam int CNT_WIDTH = 4;

`ifdef SOFT_START_EN
    localparam int c_FIRST_LVL = 1;
    localparam int c_MID_HIGH  = 4;
    localparam int c_REEN_LVL  = 1;
`else
    localparam int c_FIRST_LVL = 2;
    localparam int c_MID_HIGH  = 6;
    localparam int c_REEN_LVL  = 4;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_enable = 1'b1;
    logic [2:0] i_pwm_state = 3'd2;
    logic       o_pwm;
    logic       o_period_start;
    logic [2:0] o_active_level;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int pwm;
        int ps;
        int lvl;
    } exp_t;

    exp_t exp_q[$];

    pwm_duty_gen #(
        .PERIOD    (PERIOD),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_enable       (i_enable),
        .i_pwm_state    (i_pwm_state),
        .o_pwm          (o_pwm),
        .o_period_start (o_period_start),
        .o_active_level (o_active_level)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: position within the period and the level in force.
    int   m_pos = 0;
    bit   m_run = 0;
    int   m_lvl = 0;
    always @(posedge i_clk) begin
        exp_t e;
        int   tgt;
        cyc++;
        if (!i_reset_n || !i_enable) begin
            m_run = 0;
            m_lvl = 0;
            e = '{0, 0, 0};
        end else begin
            if (!m_run || m_pos == PERIOD - 1) begin
                tgt = (i_pwm_state <= 3'd4) ? int'(i_pwm_state) : 0;
`ifdef SOFT_START_EN
                if (tgt < m_lvl)      m_lvl = tgt;
                else if (tgt > m_lvl) m_lvl = m_lvl + 1;
`else
                m_lvl = tgt;
`endif
                m_pos = 0;
                m_run = 1;
            end else begin
                m_pos++;
            end
            e.pwm = (m_pos < (m_lvl * PERIOD) / 4) ? 1 : 0;
            e.ps  = (m_pos == 0) ? 1 : 0;
            e.lvl = m_lvl;
        end
        exp_q.push_back(e);
    end

    // Monitor: the DUT presents a new registered output every cycle.
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (int'(o_pwm) != e.pwm || int'(o_period_start) != e.ps || int'(o_active_level) != e.lvl) begin
                n_fail++;
                $display("FAIL scoreboard cyc=%0d got pwm=%0d ps=%0d lvl=%0d expected pwm=%0d ps=%0d lvl=%0d",
                         cyc, o_pwm, o_period_start, o_active_level, e.pwm, e.ps, e.lvl);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_pstart();
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge i_clk);
            if (o_period_start) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_pstart: got timeout expected period_start pulse");
    endtask

    task automatic measure(input int exp_high, input int chg_at, input logic [2:0] chg_val);
        int highs;
        highs = 0;
        wait_pstart();
        for (int k = 0; k < PERIOD; k++) begin
            if (k > 0) @(negedge i_clk);
            highs += int'(o_pwm);
            if (k == chg_at) i_pwm_state = chg_val;
        end
        check("high_count", highs, exp_high);
    endtask

    initial begin
        int seen;
        int sweep_lvl [4] = '{0, 1, 3, 4};
        int sweep_hi  [4] = '{0, 2, 6, 8};

        // Reset state, then startup wrap
        repeat (3) @(negedge i_clk);
        check("reset_pwm", int'(o_pwm), 0);
        check("reset_ps",  int'(o_period_start), 0);
        check("reset_lvl", int'(o_active_level), 0);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check("start_ps",  int'(o_period_start), 1);
        check("start_pwm", int'(o_pwm), 1);
        check("start_lvl", int'(o_active_level), c_FIRST_LVL);
        repeat (16) @(negedge i_clk);
        measure(4, -1, 3'd0);
        measure(4, -1, 3'd0);
        check("lvl2", int'(o_active_level), 2);

        // Level sweep, three periods each
        for (int s = 0; s < 4; s++) begin
            i_pwm_state = 3'(sweep_lvl[s]);
            repeat (16) @(negedge i_clk);
            measure(sweep_hi[s], -1, 3'd0);
        end
        @(negedge i_clk);
        check("full_no_gap_pwm", int'(o_pwm), 1);

        // Mid-period changes apply at the following wrap only
        i_pwm_state = 3'd1;
        repeat (16) @(negedge i_clk);
        measure(2, 3, 3'd3);
        measure(c_MID_HIGH, 3, 3'd7);
        measure(0, -1, 3'd0);

        // Enable drop mid-period at level 4, then re-enable
        i_pwm_state = 3'd4;
        repeat (40) @(negedge i_clk);
        wait_pstart();
        @(negedge i_clk);
        i_enable = 1'b0;
        @(negedge i_clk);
        check("dis_pwm", int'(o_pwm), 0);
        check("dis_ps",  int'(o_period_start), 0);
        check("dis_lvl", int'(o_active_level), 0);
        seen = 0;
        repeat (10) begin
            @(negedge i_clk);
            seen += int'(o_period_start);
        end
        check("dis_no_ps", seen, 0);
        i_enable = 1'b1;
        @(negedge i_clk);
        check("reen_ps",  int'(o_period_start), 1);
        check("reen_pwm", int'(o_pwm), 1);
        check("reen_lvl", int'(o_active_level), c_REEN_LVL);

        // Asynchronous reset mid-period
        repeat (3) @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        check("areset_pwm", int'(o_pwm), 0);
        check("areset_ps",  int'(o_period_start), 0);
        check("areset_lvl", int'(o_active_level), 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Ramp 0 -> 4, then 4 -> 1
        i_pwm_state = 3'd0;
        repeat (20) @(negedge i_clk);
        i_pwm_state = 3'd4;
`ifdef SOFT_START_EN
        for (int l = 1; l <= 4; l++) begin
            wait_pstart();
            check("ramp_lvl", int'(o_active_level), l);
        end
`else
        wait_pstart();
        check("jump_lvl", int'(o_active_level), 4);
`endif
        i_pwm_state = 3'd1;
        wait_pstart();
        check("drop_lvl", int'(o_active_level), 1);

        // Randomized traffic, checked by the scoreboard
        repeat (400) begin
            @(negedge i_clk);
            if ($urandom_range(0, 5) == 0) i_pwm_state = 3'($urandom_range(0, 7));
            i_enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 149) == 0) begin
                #2 i_reset_n = 1'b0;
                @(negedge i_clk);
                i_reset_n = 1'b1;
            end
        end

        i_enable = 1'b1;
        repeat (3) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
